scroll_sequencer: RTL
=====================

# scroll_sequencer

Per-frame scroll scheduler for the parallax city scroller. Once per frame, on the vblank tick, it runs a shared fractional-speed accumulator over the 4 layers, one layer at a time. For each layer it issues an "advance N pixels" command over a valid/ready handshake to the layer pattern generators (LFSR/counter units). It also owns the per-layer speed registers, pause and single-step control, a frame counter and an overrun flag.

## Interface
Parameters:
- NUM_LAYERS, 4: number of scrolled layers.
- SPEED_W, 6: speed width; unsigned 2.4 fixed point, in pixels per frame.
- FRAC_W, 4: fractional accumulator width per layer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- frame_tick  in  1  one-cycle pulse per frame, asserted at hcount 656, vcount 482.
- pause  in  1  level; while high, frame_tick does not start a sequence.
- single_step  in  1  pulse; arms one sequence that runs even while paused.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  0–3 select a layer speed; 4 selects control.
- cfg_data  in  6  write data.
- adv_valid  out  1  advance command valid.
- adv_ready  in  1  consumer accepts the command.
- adv_layer  out  2  layer index of the command.
- adv_pixels  out  3  pixels to advance, range 0..4.
- busy  out  1  a sequence is in progress.
- overrun  out  1  sticky: a frame_tick arrived while busy.
- frame_count  out  8  number of completed sequences, mod 256.

## Operation
- State: speed[i] (SPEED_W bits), acc[i] (FRAC_W bits), held sum register (7 bits), step_pending flag.
- FSM has 3 states:
  - IDLE: busy=0, adv_valid=0.
  - LOAD: computes sum = acc[L] + speed[L]. Registers adv_pixels = sum[6:4] and the held value new_acc = sum[3:0]. Moves to ISSUE.
  - ISSUE: adv_valid=1. Holds until adv_valid && adv_ready, then writes acc[L] <= new_acc.
    - If L < 3: L <= L+1, back to LOAD.
    - If L = 3: frame_count <= frame_count+1, go to IDLE.
- Start condition, sampled in IDLE: frame_tick && (!pause || step_pending). The sequence starts at L=0 and clears step_pending.
- single_step sets step_pending. Set and clear in the same cycle resolves to set.
- Layers are always issued in order 0..3, including layers whose adv_pixels is 0.
- frame_tick in LOAD or ISSUE: the tick is dropped and overrun <= 1.
- Config writes:
  - cfg_addr 0–3 write speed[addr] immediately.
  - A write to the layer currently in ISSUE does not change the held command; it applies from the next LOAD of that layer.
  - cfg_addr 4 with cfg_data[0]=1 clears overrun. A set in the same cycle wins.
  - cfg_addr 5–7 are ignored.
- Reset values:
  - speed = {16, 8, 4, 2}, i.e. 1, 1/2, 1/4, 1/8 px/frame.
  - acc = 0.
  - adv_valid=0, adv_layer=0, adv_pixels=0, busy=0, overrun=0, frame_count=0, step_pending=0, FSM=IDLE.
- Reset mid-sequence aborts the sequence. All state returns to reset values, and no accumulator is updated for the aborted layer.

## Timing
- Cycle 0: frame_tick is seen in IDLE. Cycle 1: LOAD, busy=1. Cycle 2: adv_valid=1 with layer 0.
- With adv_ready held high, a layer completes every 2 cycles. The sequence spans cycles 1–8; busy is low again in cycle 9, when frame_count has incremented.
- adv_layer and adv_pixels are registered and stable while adv_valid=1. adv_valid never drops without a transfer.
- The consumer may stall indefinitely. The sequence then extends, and any later frame_tick sets overrun.
- busy is high in LOAD and ISSUE only.

## Structure
- Package scroller_pkg holds:
  - NUM_LAYERS, SPEED_W, FRAC_W.
  - The default speed constants.
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, ISSUE=2'd2.
- Sub-module scroll_speed_regfile: 4×6 speed registers with reset defaults, a write port and a read port indexed by L.
- The accumulator array and the FSM stay in the top module.

## Test plan
- Reset with ready=1, one frame_tick: commands (0,1), (1,0), (2,0), (3,0) on cycles 2, 4, 6, 8; frame_count=1; busy=0 on cycle 9.
- 8 ticks at default speeds: layer 1 pixels sequence 0,1,0,1,…; layer 3 advances exactly once, on tick 8; all acc values back to 0.
- Write speed[2]=63, then one tick: layer 2 gets adv_pixels=3 and acc[2]=15. Next tick: adv_pixels=4 (sum 78), acc[2]=14.
- Hold adv_ready=0 for 20 cycles while in ISSUE of layer 1, and pulse frame_tick in that window: command stays stable, overrun=1, no extra sequence runs. Then cfg_addr=4, cfg_data=1 clears overrun.
- pause=1 with 3 ticks: no adv_valid. Then single_step followed by a tick: exactly one sequence, step_pending cleared; the next tick is ignored.
- Assert rst_n=0 during ISSUE of layer 2: the next cycle shows all outputs at reset values, and acc for layer 2 is unchanged from reset (0).

Source files
------------

// File: rtl/scroller_pkg.sv
// Shared constants, default layer speeds and FSM encoding for the parallax
// scroll sequencer.
package scroller_pkg;

  localparam int NUM_LAYERS = 4;
  localparam int SPEED_W    = 6;
  localparam int FRAC_W     = 4;
  localparam int LAYER_W    = $clog2(NUM_LAYERS);
  localparam int SUM_W      = SPEED_W + 1;
  localparam int PIX_W      = SUM_W - FRAC_W;

  // Unsigned 2.4 fixed point: 1, 1/2, 1/4, 1/8 px/frame.
  localparam logic [SPEED_W-1:0] SPEED_L0 = 6'd16;
  localparam logic [SPEED_W-1:0] SPEED_L1 = 6'd8;
  localparam logic [SPEED_W-1:0] SPEED_L2 = 6'd4;
  localparam logic [SPEED_W-1:0] SPEED_L3 = 6'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } seq_state_e;

  function automatic logic [SPEED_W-1:0] default_speed(input int unsigned idx);
    case (idx)
      0:       return SPEED_L0;
      1:       return SPEED_L1;
      2:       return SPEED_L2;
      default: return SPEED_L3;
    endcase
  endfunction

endpackage

// File: rtl/scroll_speed_regfile.sv
// Per-layer scroll speed registers: one write port from the config bus and
// one asynchronous read port indexed by the layer being sequenced.
module scroll_speed_regfile
  import scroller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [LAYER_W-1:0] waddr,
  input  logic [SPEED_W-1:0] wdata,
  input  logic [LAYER_W-1:0] raddr,
  output logic [SPEED_W-1:0] rdata
);

  logic [SPEED_W-1:0] speed_q [NUM_LAYERS];

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_speed
      logic [SPEED_W-1:0] speed_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          speed_reg <= default_speed(gi);
        end else if (we && (waddr == LAYER_W'(gi))) begin
          speed_reg <= wdata;
        end
      end

      assign speed_q[gi] = speed_reg;
    end
  endgenerate

  assign rdata = speed_q[raddr];

endmodule

// File: rtl/scroll_sequencer.sv
// Per-frame scroll scheduler: on each accepted frame tick, walks layers 0..3
// through a fractional accumulator and hands out "advance N pixels" commands.
module scroll_sequencer #(
  parameter int NUM_LAYERS = scroller_pkg::NUM_LAYERS,
  parameter int SPEED_W    = scroller_pkg::SPEED_W,
  parameter int FRAC_W     = scroller_pkg::FRAC_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          pause,
  input  logic                          single_step,
  input  logic                          cfg_we,
  input  logic [2:0]                    cfg_addr,
  input  logic [SPEED_W-1:0]            cfg_data,
  output logic                          adv_valid,
  input  logic                          adv_ready,
  output logic [$clog2(NUM_LAYERS)-1:0] adv_layer,
  output logic [2:0]                    adv_pixels,
  output logic                          busy,
  output logic                          overrun,
  output logic [7:0]                    frame_count
);

  import scroller_pkg::*;

  seq_state_e         state_reg, state_next;
  logic [LAYER_W-1:0] layer_reg, layer_next;
  logic [SUM_W-1:0]   sum_reg, sum_next;
  logic               step_pending_reg, step_pending_next;
  logic               overrun_reg, overrun_next;
  logic [7:0]         frame_count_reg, frame_count_next;

  logic               start;
  logic               acc_we;
  logic [SPEED_W-1:0] speed_rd;
  logic [FRAC_W-1:0]  acc_rd;
  logic [FRAC_W-1:0]  acc_q [NUM_LAYERS];

  scroll_speed_regfile u_speed (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && !cfg_addr[2]),
    .waddr (cfg_addr[LAYER_W-1:0]),
    .wdata (cfg_data),
    .raddr (layer_reg),
    .rdata (speed_rd)
  );

  // Accumulators only commit on a completed handshake, so an aborted layer
  // never disturbs its fractional phase.
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_acc
      logic [FRAC_W-1:0] acc_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else if (acc_we && (layer_reg == LAYER_W'(gi))) begin
          acc_reg <= sum_reg[FRAC_W-1:0];
        end
      end

      assign acc_q[gi] = acc_reg;
    end
  endgenerate

  assign acc_rd = acc_q[layer_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      layer_reg        <= '0;
      sum_reg          <= '0;
      step_pending_reg <= 1'b0;
      overrun_reg      <= 1'b0;
      frame_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      layer_reg        <= layer_next;
      sum_reg          <= sum_next;
      step_pending_reg <= step_pending_next;
      overrun_reg      <= overrun_next;
      frame_count_reg  <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    layer_next       = layer_reg;
    sum_next         = sum_reg;
    frame_count_next = frame_count_reg;
    start            = 1'b0;
    acc_we           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (frame_tick && (!pause || step_pending_reg)) begin
          start      = 1'b1;
          layer_next = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Held sum keeps the command stable even if the speed is rewritten.
        sum_next   = SUM_W'(acc_rd) + SUM_W'(speed_rd);
        state_next = ISSUE;
      end
      ISSUE: begin
        if (adv_ready) begin
          acc_we = 1'b1;
          if (layer_reg == LAYER_W'(NUM_LAYERS - 1)) begin
            frame_count_next = frame_count_reg + 8'd1;
            state_next       = IDLE;
          end else begin
            layer_next = layer_reg + LAYER_W'(1);
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (single_step) begin
      step_pending_next = 1'b1;
    end else if (start) begin
      step_pending_next = 1'b0;
    end else begin
      step_pending_next = step_pending_reg;
    end

    overrun_next = overrun_reg;
    if (cfg_we && (cfg_addr == 3'd4) && cfg_data[0]) begin
      overrun_next = 1'b0;
    end
    if (frame_tick && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign adv_valid   = (state_reg == ISSUE);
  assign adv_layer   = layer_reg;
  assign adv_pixels  = sum_reg[SUM_W-1:FRAC_W];
  assign overrun     = overrun_reg;
  assign frame_count = frame_count_reg;

endmodule
